// File: rtl/prga.sv
// ---------------------------------------------------------------------------
// prga - pseudo-random generation stage of the ARC4 decryption circuit.
//
// Runs the ARC4 keystream over the key-scheduled S array left in s_mem by
// ksa, XORs it with a length-prefixed ciphertext from ct_mem and writes the
// length-prefixed plaintext to pt_mem. S is swapped in place.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   en         start request, sampled only while rdy=1
//   rdy        idle and able to accept en
//   s_addr     S memory address
//   s_rddata   S memory read data (valid the cycle after s_addr)
//   s_wrdata   S memory write data
//   s_wren     S memory write enable
//   ct_addr    ciphertext address (byte 0 = length)
//   ct_rddata  ciphertext read data
//   pt_addr    plaintext address (byte 0 = length)
//   pt_wrdata  plaintext write data
//   pt_wren    plaintext write enable
//   pt_ok      plaintext-printable flag
//
// Build option: define PRGA_PRINTABLE_CHECK_EN to build the printable check
// behind pt_ok. Without it pt_ok is tied to 0.
//
// All outputs are registered; each state's actions are applied on the edge
// that leaves that state, so every memory read gets one wait state before
// its data is captured.
// ---------------------------------------------------------------------------
module prga #(
    parameter int MSG_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [7:0]        s_addr,
    input  logic [7:0]        s_rddata,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    output logic [MSG_AW-1:0] ct_addr,
    input  logic [7:0]        ct_rddata,
    output logic [MSG_AW-1:0] pt_addr,
    output logic [7:0]        pt_wrdata,
    output logic              pt_wren,
    output logic              pt_ok
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_RLEN, ST_WLEN, ST_PLEN,
        ST_RI, ST_WI, ST_RJ, ST_WJ,
        ST_SW1, ST_SW2, ST_RP, ST_WP, ST_WR, ST_DONE
    } state_t;

    state_t              state_q;
    logic                rdy_q;
    logic [7:0]          s_addr_q;
    logic [7:0]          s_wrdata_q;
    logic                s_wren_q;
    logic [MSG_AW-1:0]   ct_addr_q;
    logic [MSG_AW-1:0]   pt_addr_q;
    logic [7:0]          pt_wrdata_q;
    logic                pt_wren_q;

    logic [7:0]          i_q, j_q, si_q, sj_q, cb_q;
    logic [MSG_AW-1:0]   k_q, len_q;

    // Next-index / pad arithmetic, all mod 256 by width.
    logic [7:0] i_d, j_d, pad_idx_d, pt_byte_d;
    assign i_d       = i_q + 8'd1;
    assign j_d       = j_q + s_rddata;
    assign pad_idx_d = si_q + sj_q;      // registered si/sj, S is not re-read
    assign pt_byte_d = s_rddata ^ cb_q;

`ifdef PRGA_PRINTABLE_CHECK_EN
    logic pt_ok_q;
    assign pt_ok = pt_ok_q;
`else
    assign pt_ok = 1'b0;
`endif

    assign rdy       = rdy_q;
    assign s_addr    = s_addr_q;
    assign s_wrdata  = s_wrdata_q;
    assign s_wren    = s_wren_q;
    assign ct_addr   = ct_addr_q;
    assign pt_addr   = pt_addr_q;
    assign pt_wrdata = pt_wrdata_q;
    assign pt_wren   = pt_wren_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b1;
            s_addr_q    <= '0;
            s_wrdata_q  <= '0;
            s_wren_q    <= 1'b0;
            ct_addr_q   <= '0;
            pt_addr_q   <= '0;
            pt_wrdata_q <= '0;
            pt_wren_q   <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            len_q       <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            cb_q        <= '0;
`ifdef PRGA_PRINTABLE_CHECK_EN
            pt_ok_q     <= 1'b0;
`endif
        end else begin
            // Write enables are single-cycle pulses.
            s_wren_q  <= 1'b0;
            pt_wren_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (en && rdy_q) begin
                        rdy_q   <= 1'b0;
                        state_q <= ST_RLEN;
`ifdef PRGA_PRINTABLE_CHECK_EN
                        pt_ok_q <= 1'b1;
`endif
                    end
                end
                ST_RLEN: begin
                    ct_addr_q <= '0;
                    state_q   <= ST_WLEN;
                end
                ST_WLEN: state_q <= ST_PLEN;
                ST_PLEN: begin
                    len_q       <= MSG_AW'(ct_rddata);
                    pt_addr_q   <= '0;
                    pt_wrdata_q <= ct_rddata;
                    pt_wren_q   <= 1'b1;
                    if (ct_rddata == 8'd0) begin
                        state_q <= ST_DONE;
                    end else begin
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= MSG_AW'(1);
                        state_q <= ST_RI;
                    end
                end
                ST_RI: begin
                    i_q       <= i_d;
                    s_addr_q  <= i_d;
                    ct_addr_q <= k_q;
                    state_q   <= ST_WI;
                end
                ST_WI: state_q <= ST_RJ;
                ST_RJ: begin
                    si_q     <= s_rddata;
                    cb_q     <= ct_rddata;
                    j_q      <= j_d;
                    s_addr_q <= j_d;
                    state_q  <= ST_WJ;
                end
                ST_WJ: state_q <= ST_SW1;
                ST_SW1: begin
                    // When i==j both writes carry the same value, leaving S intact.
                    sj_q       <= s_rddata;
                    s_addr_q   <= i_q;
                    s_wrdata_q <= s_rddata;
                    s_wren_q   <= 1'b1;
                    state_q    <= ST_SW2;
                end
                ST_SW2: begin
                    s_addr_q   <= j_q;
                    s_wrdata_q <= si_q;
                    s_wren_q   <= 1'b1;
                    state_q    <= ST_RP;
                end
                ST_RP: begin
                    s_addr_q <= pad_idx_d;
                    state_q  <= ST_WP;
                end
                ST_WP: state_q <= ST_WR;
                ST_WR: begin
                    pt_addr_q   <= k_q;
                    pt_wrdata_q <= pt_byte_d;
                    pt_wren_q   <= 1'b1;
`ifdef PRGA_PRINTABLE_CHECK_EN
                    if ((pt_byte_d < 8'h20) || (pt_byte_d > 8'h7E)) begin
                        pt_ok_q <= 1'b0;
                    end
`endif
                    // Terminate before incrementing so k never overflows at max length.
                    if (k_q == len_q) begin
                        state_q <= ST_DONE;
                    end else begin
                        k_q     <= k_q + MSG_AW'(1);
                        state_q <= ST_RI;
                    end
                end
                ST_DONE: begin
                    rdy_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prga.sv
// ---------------------------------------------------------------------------
// tb_prga - self-checking bench for prga.
// Memory models for S and ct, a reference ARC4 model that fills a
// scoreboard of expected plaintext writes, and directed runs covering
// len=0/1/2/255, mid-run reset, held en and the pt_ok flag.
// ---------------------------------------------------------------------------
module tb_prga;
    localparam int MSG_AW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              rdy;
    logic [7:0]        s_addr;
    logic [7:0]        s_rddata;
    logic [7:0]        s_wrdata;
    logic              s_wren;
    logic [MSG_AW-1:0] ct_addr;
    logic [7:0]        ct_rddata;
    logic [MSG_AW-1:0] pt_addr;
    logic [7:0]        pt_wrdata;
    logic              pt_wren;
    logic              pt_ok;

    always #5 clk = ~clk;

    prga #(.MSG_AW(MSG_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren),
        .pt_ok     (pt_ok)
    );

    logic [7:0] s_mem   [256];
    logic [7:0] ct_mem  [256];
    logic [7:0] model_s [256];
    logic       init_s = 1'b0;

    // Synchronous-read memories; init_s reloads S with the identity.
    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (init_s) begin
            for (int n = 0; n < 256; n++) s_mem[n] <= 8'(n);
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
        end
    end

    int          checks   = 0;
    int          failures = 0;
    int          swr_cnt  = 0;
    logic [15:0] exp_q[$];
    logic        exp_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every plaintext write must match the next expected one.
    always @(negedge clk) begin
        logic [15:0] item;
        if (s_wren) swr_cnt++;
        if (pt_wren) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL pt_unexpected observed=%h:%h required=none", pt_addr, pt_wrdata);
            end else begin
                item = exp_q.pop_front();
                assert ({pt_addr, pt_wrdata} === item) else begin
                    failures++;
                    $error("FAIL pt_write observed=%h:%h required=%h:%h",
                           pt_addr, pt_wrdata, item[15:8], item[7:0]);
                end
            end
        end
    end

    task automatic init_identity();
        @(negedge clk) init_s = 1'b1;
        @(negedge clk) init_s = 1'b0;
        for (int n = 0; n < 256; n++) model_s[n] = 8'(n);
    endtask

    // Reference ARC4 PRGA over model_s and ct_mem; pushes expected writes.
    task automatic model_run();
        int         len;
        logic [7:0] i, j, t, idx, p;
        len = int'(ct_mem[0]);
        exp_q.push_back({8'h00, ct_mem[0]});
        exp_ok = 1'b1;
        i = 8'd0;
        j = 8'd0;
        for (int k = 1; k <= len; k++) begin
            i = i + 8'd1;
            j = j + model_s[i];
            t = model_s[i];
            model_s[i] = model_s[j];
            model_s[j] = t;
            idx = model_s[i] + model_s[j];
            p = ct_mem[k] ^ model_s[idx];
            exp_q.push_back({8'(k), p});
            if ((p < 8'h20) || (p > 8'h7E)) exp_ok = 1'b0;
        end
    endtask

    // Pulse en (optionally leave it high) and check rdy dropped.
    task automatic start(input string tag, input bit hold);
        swr_cnt = 0;
        @(negedge clk) en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) en = 1'b0;
        chk({tag, "_rdy_low"}, 32'(rdy), 32'd0);
    endtask

    task automatic wait_rdy(input string tag, input int exp_cycles);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!rdy && n < 5000);
        chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
        $display("run %s cycles=%0d", tag, n);
    endtask

    task automatic finish_checks(input string tag, input int len);
        int mism;
        logic exp_flag;
        mism = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== model_s[n]) mism++;
        chk({tag, "_s_mism"}, 32'(mism), 32'd0);
        chk({tag, "_s_wren"}, 32'(swr_cnt), 32'(2 * len));
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
`ifdef PRGA_PRINTABLE_CHECK_EN
        exp_flag = exp_ok;
`else
        exp_flag = 1'b0;
`endif
        chk({tag, "_pt_ok"}, 32'(pt_ok), 32'(exp_flag));
    endtask

    task automatic run(input string tag, input int len);
        model_run();
        start(tag, 1'b0);
        wait_rdy(tag, 4 + 9 * len);
        finish_checks(tag, len);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_s_wren", 32'(s_wren), 32'd0);
        chk("rst_pt_wren", 32'(pt_wren), 32'd0);
        chk("rst_addrs", {8'(s_addr), 8'(ct_addr), 8'(pt_addr), 8'(pt_wrdata)}, 32'd0);
        chk("rst_pt_ok", 32'(pt_ok), 32'd0);
        rst_n = 1'b1;

        // len=1 on identity S: pt={01,02}, S unchanged, 13 cycles.
        init_identity();
        ct_mem[0] = 8'h01; ct_mem[1] = 8'h00;
        run("len1", 1);

        // len=2: pt={02,02,05}, S[2]/S[3] swapped, 22 cycles.
        init_identity();
        ct_mem[0] = 8'h02; ct_mem[1] = 8'h00; ct_mem[2] = 8'h00;
        run("len2", 2);
        chk("len2_s2", 32'(s_mem[2]), 32'h03);
        chk("len2_s3", 32'(s_mem[3]), 32'h02);

        // len=0: only pt[0], no S writes, 4 cycles.
        init_identity();
        ct_mem[0] = 8'h00;
        run("len0", 0);

        // Reset during SW1 of byte 1 (cycle after the 8th edge past accept).
        init_identity();
        ct_mem[0] = 8'h01; ct_mem[1] = 8'h00;
        model_run();
        start("mid", 1'b0);
        repeat (8) @(negedge clk);
        chk("mid_sw1_wren", 32'(s_wren), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_rdy", 32'(rdy), 32'd1);
        chk("mid_rst_wren", {30'd0, s_wren, pt_wren}, 32'd0);
        chk("mid_rst_addrs", {8'(s_addr), 8'(ct_addr), 8'(pt_addr), 8'(s_wrdata)}, 32'd0);
        chk("mid_sb_left", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        init_identity();
        run("after_rst", 1);

        // en held high through a len=2 run: a second run starts only after rdy.
        init_identity();
        ct_mem[0] = 8'h02; ct_mem[1] = 8'h00; ct_mem[2] = 8'h00;
        model_run();
        start("hold", 1'b1);
        wait_rdy("hold", 22);
        finish_checks("hold", 2);
        model_run();
        swr_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        chk("hold_rerun_rdy", 32'(rdy), 32'd0);
        wait_rdy("hold2", 22);
        finish_checks("hold2", 2);

        // Printable check.
        init_identity();
        ct_mem[0] = 8'h01; ct_mem[1] = 8'h43;
        run("print_a", 1);
        init_identity();
        ct_mem[0] = 8'h01; ct_mem[1] = 8'h00;
        run("print_bad", 1);

        // Maximum length: k must stop at len without wrapping.
        init_identity();
        ct_mem[0] = 8'hFF;
        for (int n = 1; n < 256; n++) ct_mem[n] = 8'($urandom_range(255, 0));
        run("maxlen", 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prga.md
Name: prga

Overview:
- Pseudo-random generation stage of the ARC4 decryption circuit.
- Sits directly downstream of ksa and consumes the key-scheduled S array that ksa leaves in s_mem.
- Reads a length-prefixed ciphertext from ct_mem, runs the ARC4 keystream over S, and writes the length-prefixed plaintext into pt_mem.
- Swaps S in place, exactly as the algorithm requires.

Parameters:
- MSG_AW, 8, address width of ct_mem/pt_mem. Byte 0 holds the length; the maximum length is 2^MSG_AW-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  high when idle and able to accept en
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- ct_addr  out  MSG_AW  ciphertext memory address
- ct_rddata  in  8  ciphertext read data
- pt_addr  out  MSG_AW  plaintext memory address
- pt_wrdata  out  8  plaintext write data
- pt_wren  out  1  plaintext write enable
- pt_ok  out  1  plaintext-printable flag (see Optional Feature)

Behaviour:
- Memories: synchronous read. rddata is valid in the cycle after the address is presented. A write commits at the edge where wren=1.
- Reset (rst_n=0 at an edge), taking effect on any cycle including mid-operation:
  - state=IDLE, rdy=1, s_wren=0, pt_wren=0
  - all addresses and wrdata = 0, pt_ok=0
  - internal i, j, k = 0
- Memory contents already written are not restored on reset.
- Handshake:
  - en is accepted when rdy=1 and en=1 at an edge; rdy drops the next cycle.
  - en while rdy=0 is ignored.
  - rdy returns to 1 when the output is complete and stays high until the next accept.
- Arithmetic: i, j, S-index sums are 8-bit with mod-256 wrap. k counts 1..len.
- FSM states:
  - IDLE
  - RLEN: ct_addr=0.
  - WLEN: wait state.
  - PLEN: len=ct_rddata; pt_addr=0, pt_wrdata=len, pt_wren=1. If len=0 go to DONE, else i=0, j=0, k=1 and go to RI.
  - RI: i'=i+1; s_addr=i', ct_addr=k.
  - WI: wait state.
  - RJ: si=s_rddata, cb=ct_rddata, j'=j+si; s_addr=j'.
  - WJ: wait state.
  - SW1: sj=s_rddata; s_addr=i, s_wrdata=sj, s_wren=1.
  - SW2: s_addr=j, s_wrdata=si, s_wren=1.
  - RP: s_addr=si+sj (mod 256).
  - WP: wait state.
  - WR: pt_addr=k, pt_wrdata=s_rddata^cb, pt_wren=1. If k==len go to DONE, else k=k+1 and go to RI.
  - DONE: rdy=1 and go to IDLE.
- Write enables are high in exactly one cycle per write and otherwise 0.
- i==j: both swap writes still occur with equal data, so S is unchanged.
- The pad index uses the registered si/sj, never re-read S.
- Timing: 9 cycles per byte. rdy is high again at edge 4+9·len after the accepting edge.
  - len=0: 4 cycles; only pt[0] is written; no S writes.
- Maximum length: len=2^MSG_AW-1 must terminate via k==len without overflowing k.
- Nothing is written to ct_mem; s_mem is touched only by the swap writes.

Optional Feature:
- Macro: PRGA_PRINTABLE_CHECK_EN
- Defined:
  - pt_ok is set to 1 at acceptance of en.
  - pt_ok is cleared at any WR whose pt_wrdata is outside 0x20..0x7E.
  - pt_ok is valid whenever rdy=1 after a run; len=0 gives pt_ok=1.
  - Intended for the key-search stage.
- Undefined: pt_ok is constant 0 and no compare logic is built.

Test Plan:
- len=1: S preloaded identity (S[n]=n), ct={0x01,0x00}, pulse en.
  - pt[0]=0x01, pt[1]=0x02, S unchanged.
  - rdy high again 13 cycles after accept.
- len=2: identity S, ct={0x02,0x00,0x00}.
  - pt={0x02,0x02,0x05}; S[2]=0x03, S[3]=0x02, all other S[n]=n.
  - rdy after 22 cycles.
- len=0: ct={0x00}.
  - pt[0]=0x00, no s_wren pulses, rdy after 4 cycles.
- Reset mid-run: rst_n=0 for one cycle during the SW1 state of byte 1.
  - Next cycle: rdy=1, all wren=0, state IDLE.
  - A following en with fresh identity S runs the len=1 case correctly.
- en asserted continuously through a len=2 run:
  - Only one run occurs; a second run starts only on the edge after rdy returns to 1.
- PRGA_PRINTABLE_CHECK_EN defined, identity S:
  - ct={0x01,0x43} → pt[1]=0x41, pt_ok=1.
  - ct={0x01,0x00} → pt[1]=0x02, pt_ok=0.
  - Without the macro, pt_ok=0 in both cases.
